// File: rtl/ysyx_23060332_ctrl.sv
// Multi-cycle instruction sequencer for the NPC core: owns pc, the instruction
// register and the retired counter, and walks FETCH -> EXEC -> [MEM] -> WB.
module ysyx_23060332_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr,
  input  logic        reg_wen_dec,
  output logic        reg_wen_o,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        lsu_req,
  input  logic        lsu_ready,
  output logic [31:0] instret,
  output logic        halt,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam logic [31:0] INST_EBRK  = 32'h0010_0073;
  localparam logic [6:0]  OP_LOAD    = 7'b0000011;
  localparam logic [6:0]  OP_STORE   = 7'b0100011;
  localparam logic [15:0] TCNT_LAST  = 16'(FETCH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;
  logic        ifu_req_q, ifu_req_d;
  logic        lsu_req_q, lsu_req_d;

  logic        misaligned;
  logic        is_mem;

  assign misaligned = jump_flag && (jump_addr[1:0] != 2'b00);
  assign is_mem     = (inst_q[6:0] == OP_LOAD) || (inst_q[6:0] == OP_STORE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    tcnt_d    = tcnt_q;
    halt_d    = halt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        tcnt_d  = 16'd0;
      end
      S_FETCH: begin
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          state_d = S_EXEC;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_EXEC: begin
        if (inst_q == INST_EBRK) begin
          state_d   = S_HALT;
          halt_d    = 1'b1;
          err_d     = 1'b0;
          instret_d = instret_q + 32'd1;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_ready) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        // A misaligned target aborts the instruction: no pc update, no retire.
        if (misaligned) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          pc_d      = jump_flag ? jump_addr : pc_q + 32'd4;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
          tcnt_d    = 16'd0;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request strobes are registered from the next state so they track the state register.
  assign ifu_req_d = (state_d == S_FETCH);
  assign lsu_req_d = (state_d == S_MEM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= INST_NOP;
      instret_q <= 32'd0;
      tcnt_q    <= 16'd0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      ifu_req_q <= 1'b0;
      lsu_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      tcnt_q    <= tcnt_d;
      halt_q    <= halt_d;
      err_q     <= err_d;
      ifu_req_q <= ifu_req_d;
      lsu_req_q <= lsu_req_d;
    end
  end

  assign ifu_req   = ifu_req_q;
  assign ifu_addr  = pc_q;
  assign inst_o    = inst_q;
  assign inst_addr = pc_q;
  assign lsu_req   = lsu_req_q;
  assign reg_wen_o = (state_q == S_WB) && reg_wen_dec && !misaligned;
  assign instret   = instret_q;
  assign halt      = halt_q;
  assign err       = err_q;

endmodule
